// File: rtl/trace_pkg.sv
// trace_pkg: commit trace record layout and memory-size encodings.
package trace_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        is_load;
        logic        is_store;
        logic        is_float;
        logic [1:0]  mem_size;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic [4:0]  fflags;
    } trace_rec_t;
    localparam int REC_W = $bits(trace_rec_t);
    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
endpackage

// File: rtl/trace_mpush_fifo.sv
// trace_mpush_fifo: DEPTH-entry in-order FIFO, up to NUM_LANES compacted writes and one read per cycle.
module trace_mpush_fifo #(
    parameter int NUM_LANES = 2,
    parameter int DEPTH = 16,
    parameter int W = 8,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int NW = $clog2(NUM_LANES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [NW-1:0]          wr_n_i,
    input  logic [NUM_LANES*W-1:0] wr_data_i,
    input  logic                   rd_i,
    output logic [W-1:0]           rd_data_o,
    output logic [CW-1:0]          count_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic pop;

    assign pop = rd_i && count_q != '0;
    assign rd_data_o = count_q != '0 ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

    always_comb begin
        wptr_d = flush_i ? '0 : wptr_q + PW'(wr_n_i);
        rptr_d = flush_i ? '0 : rptr_q + PW'(pop);
        count_d = flush_i ? '0 : count_q + CW'(wr_n_i) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            count_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: reads are gated by count.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < NUM_LANES; j++)
            if (NW'(j) < wr_n_i) mem_q[wptr_q + PW'(j)] <= wr_data_i[j*W +: W];
    end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: multi-lane commit capture with sequence stamping, whole-group drop and a drain port.
// Define COMMIT_TRACE_FILE_EN to also print a text trace of every popped record (simulation only).
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DEPTH = 16,
    parameter int SEQ_W = 32,
    parameter int DROP_CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       flush_i,
    input  logic [NUM_LANES-1:0]       commit_valid_i,
    input  logic [NUM_LANES*REC_W-1:0] commit_rec_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [SEQ_W-1:0]           out_seq_o,
    output logic [REC_W-1:0]           out_rec_o,
    output logic                       overflow_o,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o
);
    localparam int NW = $clog2(NUM_LANES + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = SEQ_W + REC_W;

    logic [NUM_LANES-1:0] lane_v;
    logic [NW-1:0] n, push_n;
    logic [NUM_LANES*EW-1:0] comp;
    logic [CW-1:0] count;
    logic accept;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic [DROP_CNT_W:0] drop_sum;
    logic [EW-1:0] head;

    assign lane_v = commit_valid_i & {NUM_LANES{enable_i}};

    // Compact valid lanes oldest-first; each slot carries its own sequence number.
    always_comb begin
        n = '0;
        comp = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (lane_v[i]) begin
                comp[int'(n)*EW +: EW] = {seq_q + SEQ_W'(n), commit_rec_i[i*REC_W +: REC_W]};
                n = n + NW'(1);
            end
    end

    assign accept = int'(n) <= DEPTH - int'(count);
    assign push_n = (accept && !flush_i) ? n : '0;
    assign drop_sum = {1'b0, drop_q} + (DROP_CNT_W+1)'(n);

    always_comb begin
        seq_d = seq_q + SEQ_W'(n);
        ovf_d = flush_i ? 1'b0 : ovf_q || !accept;
        drop_d = flush_i ? '0 : !accept ? (drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0]) : drop_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            seq_q <= '0;
            ovf_q <= 1'b0;
            drop_q <= '0;
        end else begin
            seq_q <= seq_d;
            ovf_q <= ovf_d;
            drop_q <= drop_d;
        end
    end

    trace_mpush_fifo #(.NUM_LANES(NUM_LANES), .DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .flush_i(flush_i),
        .wr_n_i(push_n),
        .wr_data_i(comp),
        .rd_i(out_ready_i),
        .rd_data_o(head),
        .count_o(count)
    );

    assign out_valid_o = count != '0;
    assign {out_seq_o, out_rec_o} = head;
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;

`ifdef COMMIT_TRACE_FILE_EN
    logic [SEQ_W-1:0] log_seq;
    trace_rec_t lr;
    string ln;
    assign lr = out_rec_o;
    initial log_seq = '0;
    always @(posedge clk_i) begin
        if (!rst_ni) log_seq <= '0;
        else if (out_valid_o && out_ready_i) begin
            if (out_seq_o != log_seq) $display("# dropped %0d", out_seq_o - log_seq);
            ln = $sformatf("0x%08h (0x%08h)", lr.pc, lr.instr);
            if (lr.is_store) begin
                if (lr.mem_size == MEM_SIZE_B) ln = {ln, $sformatf(" mem 0x%08h 0x%02h", lr.mem_addr, lr.mem_data[7:0])};
                else if (lr.mem_size == MEM_SIZE_H) ln = {ln, $sformatf(" mem 0x%08h 0x%04h", lr.mem_addr, lr.mem_data[15:0])};
                else ln = {ln, $sformatf(" mem 0x%08h 0x%08h", lr.mem_addr, lr.mem_data)};
            end else if (lr.is_float) begin
                if (lr.fflags != '0) ln = {ln, $sformatf(" c1_fflags 0x%02h", lr.fflags)};
                ln = {ln, $sformatf(" f%0d 0x%08h", lr.rd, lr.rd_data)};
            end else if (lr.rd != '0) begin
                if (lr.rd < 5'd10) ln = {ln, $sformatf(" x%0d  0x%08h", lr.rd, lr.rd_data)};
                else ln = {ln, $sformatf(" x%0d 0x%08h", lr.rd, lr.rd_data)};
            end
            if (lr.is_load) ln = {ln, $sformatf(" mem 0x%08h", lr.mem_addr)};
            $display("%s", ln);
            log_seq <= out_seq_o + SEQ_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed scenarios plus random traffic, scored against a queue-based model.
module tb_commit_trace_buffer;
    import trace_pkg::*;
    localparam int NL = 4;
    localparam int DP = 4;
    localparam int SW = 8;
    localparam int DW = 4;
    localparam int DMAX = (1 << DW) - 1;

    typedef struct {
        logic [SW-1:0] seq;
        logic [REC_W-1:0] rec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0, enable = 1'b0, flush = 1'b0, ready = 1'b0;
    logic [NL-1:0] cvalid = '0;
    logic [NL*REC_W-1:0] crec = '0;
    logic out_valid, ovf;
    logic [SW-1:0] out_seq;
    logic [REC_W-1:0] out_rec;
    logic [DW-1:0] drop;

    exp_t exp_q[$];
    int mcount = 0, mseq = 0, mdrop = 0;
    bit movf = 1'b0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.NUM_LANES(NL), .DEPTH(DP), .SEQ_W(SW), .DROP_CNT_W(DW)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .enable_i(enable),
        .flush_i(flush),
        .commit_valid_i(cvalid),
        .commit_rec_i(crec),
        .out_valid_o(out_valid),
        .out_ready_i(ready),
        .out_seq_o(out_seq),
        .out_rec_o(out_rec),
        .overflow_o(ovf),
        .drop_cnt_o(drop)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, then apply the architectural rules to the model for the edge just taken.
    task automatic cyc(input logic rst, input logic en, input logic fl, input logic [NL-1:0] m, input logic rdy);
        logic [191:0] t;
        int n, k;
        bit pop;
        exp_t e;
        rst_n = rst; enable = en; flush = fl; cvalid = m; ready = rdy;
        for (int i = 0; i < NL; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            crec[i*REC_W +: REC_W] = t[REC_W-1:0];
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            exp_q.delete();
            mcount = 0; mseq = 0; movf = 0; mdrop = 0;
            chk("reset_valid", out_valid, 0);
            chk("reset_seq", out_seq, 0);
            chk("reset_rec", out_rec, 0);
            chk("reset_ovf", ovf, 0);
            chk("reset_drop", drop, 0);
        end else begin
            n = 0;
            for (int i = 0; i < NL; i++) if (en && m[i]) n++;
            pop = rdy && mcount > 0;
            if (fl) begin
                exp_q.delete();
                mcount = 0; movf = 0; mdrop = 0;
            end else if (n <= DP - mcount) begin
                k = 0;
                for (int i = 0; i < NL; i++)
                    if (en && m[i]) begin
                        e.seq = SW'((mseq + k) % (1 << SW));
                        e.rec = crec[i*REC_W +: REC_W];
                        exp_q.push_back(e);
                        k++;
                    end
                mcount = mcount + n - int'(pop);
            end else begin
                movf = 1;
                mdrop = (mdrop + n > DMAX) ? DMAX : mdrop + n;
                mcount = mcount - int'(pop);
            end
            mseq = (mseq + n) % (1 << SW);
        end
    endtask

    // Monitor: checks head against the scoreboard every cycle and retires it on valid && ready.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("out_valid", out_valid, mcount != 0);
            chk("overflow", ovf, movf);
            chk("drop_cnt", drop, mdrop);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("head_expected", out_valid, 0);
                else begin
                    chk("head_seq", out_seq, exp_q[0].seq);
                    chk("head_rec", out_rec, exp_q[0].rec);
                    if (ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 4'b0001, 1);
        repeat (2) cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 4'b0011, 1);
        repeat (3) cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 4'b1010, 1);
        repeat (3) cyc(1, 1, 0, 0, 1);
        // Two groups fill the FIFO; the third is dropped whole.
        repeat (3) cyc(1, 1, 0, 4'b0011, 0);
        repeat (5) cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 4'b0001, 1);
        repeat (2) cyc(1, 1, 0, 0, 1);
        // Full FIFO: a same-cycle pop gives no room, then head held under back-pressure.
        cyc(1, 1, 0, 4'b1111, 0);
        cyc(1, 1, 0, 4'b0001, 1);
        repeat (3) cyc(1, 1, 0, 0, 0);
        repeat (4) cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 0, 4'b1111, 1);
        cyc(1, 1, 0, 4'b1111, 0);
        repeat (4) cyc(1, 1, 0, 4'b1111, 0);
        repeat (2) cyc(1, 1, 0, 4'b1111, 1);
        // Flush with records queued, then a fresh push.
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 0, 4'b0111, 0);
        cyc(1, 1, 1, 4'b0001, 0);
        cyc(1, 1, 0, 4'b0001, 1);
        repeat (2) cyc(1, 1, 0, 0, 1);
        // Reset in the middle of a drain.
        cyc(1, 1, 0, 4'b0111, 0);
        cyc(1, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(1, 1, 0, 4'b0100, 1);
        repeat (2) cyc(1, 1, 0, 0, 1);
        for (int c = 0; c < 3000; c++)
            cyc($urandom_range(199) != 0, $urandom_range(9) < 8, $urandom_range(29) == 0,
                NL'($urandom), $urandom_range(9) < 6);
        repeat (6) cyc(1, 1, 0, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
